// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one WIDTH-bit up-counter among N requesters.
// Optional abort port enabled by defining CNT_SCHED_ABORT_EN.
module cnt_sched #(
  parameter  int N     = 4,
  parameter  int WIDTH = 2,
  localparam int IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rstb,
`ifdef CNT_SCHED_ABORT_EN
  input  logic               abort,
`endif
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] len,
  output logic [N-1:0]       gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   out,
  output logic               done,
  output logic [IDW-1:0]     done_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr, id, win;
  logic [WIDTH-1:0] tlen, cnt;
  logic             any, stop;

`ifdef CNT_SCHED_ABORT_EN
  assign stop = abort;
`else
  assign stop = 1'b0;
`endif

  // Scan from the farthest offset down so the nearest set bit after ptr wins;
  // IDW-bit addition wraps mod N because N is a power of two.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[ptr + IDW'(i)]) begin
        win = ptr + IDW'(i);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= IDLE;
      ptr   <= '0;
      id    <= '0;
      tlen  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state <= LOAD;
          id    <= win;
          tlen  <= len[int'(win)*WIDTH +: WIDTH];
          ptr   <= win + IDW'(1);
          cnt   <= '0;
        end
        LOAD: state <= stop ? DONE : RUN;
        // Counting stops at tlen, so cnt never wraps and holds through DONE.
        RUN: begin
          if (stop || cnt == tlen) state <= DONE;
          else                     cnt   <= cnt + WIDTH'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == LOAD) || (state == RUN);
  assign gnt     = busy ? ({{(N-1){1'b0}}, 1'b1} << id) : '0;
  assign out     = cnt;
  assign done    = (state == DONE);
  assign done_id = done ? id : '0;

endmodule

// File: tb/tb_cnt_sched.sv
// Bench for cnt_sched: directed test-plan steps followed by random traffic,
// checked against a burst-trace reference model.
module tb_cnt_sched;
  localparam int N   = 4;
  localparam int W   = 2;
  localparam int IDW = 2;
  localparam int LW  = N * W;

  logic          clk = 1'b0;
  logic          rstb;
  logic          abort;
  logic [N-1:0]  req;
  logic [LW-1:0] len;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [W-1:0]  out;
  logic          done;
  logic [IDW-1:0] done_id;

  cnt_sched #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rstb(rstb),
`ifdef CNT_SCHED_ABORT_EN
    .abort(abort),
`endif
    .req(req), .len(len), .gnt(gnt), .busy(busy), .out(out),
    .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   g;
    logic           b;
    logic [W-1:0]   o;
    logic           d;
    logic [IDW-1:0] di;
  } ent_t;

  // Expected per-cycle trace of the burst in flight; empty means idle.
  ent_t q[$];
  int   mptr;
  int   passes = 0;
  int   total  = 0;
  ent_t e;

  function automatic ent_t mk(logic [N-1:0] g, logic b, logic [W-1:0] o, logic d, logic [IDW-1:0] di);
    ent_t r;
    r.g = g; r.b = b; r.o = o; r.d = d; r.di = di;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    int win, tl;
    ent_t f;
    if (rstb) begin
      q.delete();
      mptr = 0;
    end else if (q.size() != 0) begin
      f = q[0];
      if (abort && f.b) begin
`ifdef CNT_SCHED_ABORT_EN
        q.delete();
        q.push_back(mk('0, 1'b0, f.o, 1'b1, f.di));
`else
        void'(q.pop_front());
`endif
      end else begin
        void'(q.pop_front());
      end
    end else if (req != '0) begin
      win = -1;
      for (int i = 0; i < N; i++)
        if (win < 0 && req[(mptr + i) % N]) win = (mptr + i) % N;
      tl   = int'(len[win*W +: W]);
      mptr = (win + 1) % N;
      q.push_back(mk(N'(1) << win, 1'b1, '0, 1'b0, IDW'(win)));
      for (int c = 0; c <= tl; c++) q.push_back(mk(N'(1) << win, 1'b1, W'(c), 1'b0, IDW'(win)));
      q.push_back(mk('0, 1'b0, W'(tl), 1'b1, IDW'(win)));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = (q.size() != 0) ? q[0] : mk('0, 1'b0, '0, 1'b0, '0);
    chk("gnt",  32'(gnt),  32'(e.g));
    chk("busy", 32'(busy), 32'(e.b));
    chk("done", 32'(done), 32'(e.d));
    if (e.b || e.d) chk("out", 32'(out), 32'(e.o));
    if (e.d) chk("done_id", 32'(done_id), 32'(e.di));
  endtask

  initial begin
    rstb = 1'b1; req = 4'b1111; len = '0; abort = 1'b0;
    cyc(); cyc();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    rstb = 1'b0;
    cyc();
    chk("first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (4) cyc();

    // single burst, len[2]=2
    req = 4'b0100; len[5:4] = 2'd2;
    cyc();
    chk("single_gnt", 32'(gnt), 32'b0100);
    req = '0;
    repeat (6) cyc();

    // round robin, all len=0
    req = 4'b1111; len = '0;
    repeat (21) cyc();
    req = '0;
    repeat (5) cyc();

    // length boundaries on requester 1
    req = 4'b0010; len[3:2] = 2'd0;
    cyc(); req = '0;
    repeat (4) cyc();
    req = 4'b0010; len[3:2] = 2'd3;
    cyc(); req = '0;
    repeat (7) cyc();
    chk("max_hold", 32'(out), 32'd3);

    // mid-burst len change and req drop
    req = 4'b0001; len[1:0] = 2'd3;
    cyc(); cyc();
    len[1:0] = 2'd1; req = '0;
    repeat (6) cyc();

    // reset during RUN
    req = 4'b0100; len[5:4] = 2'd3;
    repeat (3) cyc();
    rstb = 1'b1;
    cyc();
    chk("rst_mid_out", 32'(out), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rstb = 1'b0; req = '0;
    repeat (3) cyc();

`ifdef CNT_SCHED_ABORT_EN
    req = 4'b1000; len[7:6] = 2'd3;
    cyc(); req = '0;
    cyc(); cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_out", 32'(out), 32'd1);
    chk("abort_id", 32'(done_id), 32'd3);
    repeat (2) cyc();
`endif

    repeat (500) begin
      req  = N'($urandom);
      len  = LW'($urandom);
      rstb = ($urandom_range(0, 99) == 0);
`ifdef CNT_SCHED_ABORT_EN
      abort = ($urandom_range(0, 15) == 0);
`endif
      cyc();
    end
    rstb = 1'b0; abort = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
